// File: rtl/branch_predict_unit.sv
// Branch resolution plus a BHT of 2-bit saturating counters read by fetch and trained by execute.
// Optional performance counters (br_count, miss_count) are enabled with `define BPU_PERF_COUNTERS_EN.
module branch_predict_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_pred,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            cf,
    input  logic            zf,
    input  logic            vf,
    input  logic            sf,
    output logic [1:0]      pc_selection,
    output logic            mispredict,
    output logic            flush
`ifdef BPU_PERF_COUNTERS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     miss_count
`endif
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [1:0]       bht [DEPTH];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] res_idx;
    logic             is_branch;
    logic             supported;
    logic             cond;
    logic             train;
    logic             act;
    logic             unused_pc_bits;

    assign fetch_idx  = fetch_pc[IDX_W+1:2];
    assign res_idx    = res_pc[IDX_W+1:2];
    assign pred_taken = bht[fetch_idx][1];

    assign unused_pc_bits = ^{fetch_pc[1:0], fetch_pc[XLEN-1:IDX_W+2],
                              res_pc[1:0], res_pc[XLEN-1:IDX_W+2]};

    always_comb begin
        supported = 1'b1;
        cond      = 1'b0;
        case (funct3)
            3'b000:  cond = zf;
            3'b001:  cond = !zf;
            3'b100:  cond = (sf != vf);
            3'b101:  cond = (sf == vf);
            3'b110:  cond = !cf;
            3'b111:  cond = cf;
            default: supported = 1'b0;
        endcase
    end

    assign is_branch = (opcode == OP_BRANCH);
    assign train     = res_valid && is_branch && supported;
    assign act       = train && cond;

    always_comb begin
        pc_selection = 2'b00;
        if (res_valid) begin
            if (opcode == OP_JAL)
                pc_selection = 2'b10;
            else if (opcode == OP_JALR)
                pc_selection = 2'b01;
            else if (act)
                pc_selection = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                bht[i[IDX_W-1:0]] <= 2'b01;
            mispredict <= 1'b0;
            flush      <= 1'b0;
        end else begin
            if (train) begin
                if (act && bht[res_idx] != 2'b11)
                    bht[res_idx] <= bht[res_idx] + 2'd1;
                else if (!act && bht[res_idx] != 2'b00)
                    bht[res_idx] <= bht[res_idx] - 2'd1;
            end
            mispredict <= train && (act != res_pred);
            flush      <= train && (act != res_pred);
        end
    end

`ifdef BPU_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (train)
                br_count <= br_count + 32'd1;
            if (train && (act != res_pred))
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus queues expected values tagged with the cycle
// they must appear in; a negedge monitor compares and retires them.
module tb_branch_predict_unit;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int K_PRED = 0, K_SEL = 1, K_MIS = 2, K_FLUSH = 3, K_BR = 4, K_MISS = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_pred;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        cf, zf, vf, sf;
    logic [1:0]  pc_selection;
    logic        mispredict;
    logic        flush;
`ifdef BPU_PERF_COUNTERS_EN
    logic [31:0] br_count;
    logic [31:0] miss_count;
`endif

    branch_predict_unit #(.XLEN(32), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_pred(res_pred),
        .opcode(opcode), .funct3(funct3), .cf(cf), .zf(zf), .vf(vf), .sf(sf),
        .pc_selection(pc_selection), .mispredict(mispredict), .flush(flush)
`ifdef BPU_PERF_COUNTERS_EN
        , .br_count(br_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_miss = 0;

    function automatic logic [31:0] actual(int kind);
        case (kind)
            K_PRED:  return {31'd0, pred_taken};
            K_SEL:   return {30'd0, pc_selection};
            K_MIS:   return {31'd0, mispredict};
            K_FLUSH: return {31'd0, flush};
`ifdef BPU_PERF_COUNTERS_EN
            K_BR:    return br_count;
            K_MISS:  return miss_count;
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: retire every expectation due this cycle; anything overdue is an error.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].at == cyc) begin
                    checks++;
                    if (actual(q[i].kind) !== q[i].exp) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%0h want=%0h", q[i].name, cyc,
                                 actual(q[i].kind), q[i].exp);
                    end
                    q.delete(i);
                end else if (q[i].at < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s stale expectation for cyc=%0d", q[i].name, q[i].at);
                    q.delete(i);
                end
            end
        end
    end

    task automatic expect_v(input int kind, input logic [31:0] v, input string name, input int off);
        exp_t e;
        e.at = cyc + off; e.kind = kind; e.exp = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res_valid = 1'b0; res_pc = '0; res_pred = 1'b0;
        opcode = '0; funct3 = '0;
        {cf, zf, vf, sf} = 4'b0000;
    endtask

    // Resolve a conditional branch this cycle; fl = {cf,zf,vf,sf}.
    task automatic br(input logic [2:0] f3, input logic [3:0] fl, input logic [31:0] rpc,
                      input logic rpred, input logic [1:0] sel, input logic mis,
                      input logic sup, input string name);
        res_valid = 1'b1; opcode = OP_BRANCH; funct3 = f3; res_pc = rpc; res_pred = rpred;
        {cf, zf, vf, sf} = fl;
        expect_v(K_SEL, {30'd0, sel}, {name, "_sel"}, 0);
        expect_v(K_MIS, {31'd0, mis}, {name, "_mis"}, 1);
        expect_v(K_FLUSH, {31'd0, mis}, {name, "_flush"}, 1);
        if (sup) exp_br++;
        if (mis) exp_miss++;
    endtask

    initial begin
        idle();
        fetch_pc = 32'h100;
        rst = 1'b0;
        // Reset state
        cycle();
        expect_v(K_MIS, 0, "rst_mis", 0);
        expect_v(K_FLUSH, 0, "rst_flush", 0);
        expect_v(K_PRED, 0, "rst_pred100", 0);
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            fetch_pc = i * 4;
            expect_v(K_PRED, 0, "sweep_pred", 0);
            cycle();
        end

        // Saturating training at 0x40
        fetch_pc = 32'h40; expect_v(K_PRED, 0, "sat_p0", 0);
        br(3'b000, 4'b0100, 32'h40, 1'b0, 2'b10, 1'b1, 1'b1, "beq1");
        cycle(); expect_v(K_PRED, 1, "sat_p1", 0);
        br(3'b000, 4'b0100, 32'h40, 1'b1, 2'b10, 1'b0, 1'b1, "beq2");
        cycle(); expect_v(K_PRED, 1, "sat_p2", 0);
        br(3'b000, 4'b0100, 32'h40, 1'b1, 2'b10, 1'b0, 1'b1, "beq3");
        cycle(); idle(); expect_v(K_PRED, 1, "sat_p3", 0);
        cycle(); expect_v(K_PRED, 1, "sat_p4", 0);
        br(3'b000, 4'b0000, 32'h40, 1'b1, 2'b00, 1'b1, 1'b1, "beq_nt1");
        cycle(); idle(); expect_v(K_PRED, 1, "sat_dec1", 0);
        cycle(); expect_v(K_PRED, 1, "sat_p5", 0);
        br(3'b000, 4'b0000, 32'h40, 1'b1, 2'b00, 1'b1, 1'b1, "beq_nt2");
        cycle(); idle(); expect_v(K_PRED, 0, "sat_dec2", 0);

        // Mispredict pulse on BNE
        cycle(); fetch_pc = 32'h80; expect_v(K_PRED, 0, "bne_p0", 0);
        br(3'b001, 4'b0000, 32'h80, 1'b0, 2'b10, 1'b1, 1'b1, "bne_miss");
        cycle(); idle();
        expect_v(K_SEL, 0, "idle_sel", 0);
        expect_v(K_PRED, 1, "bne_p1", 0);
        expect_v(K_MIS, 0, "pulse_end", 1);
        cycle();
        br(3'b001, 4'b0000, 32'h80, 1'b1, 2'b10, 1'b0, 1'b1, "bne_hit");
        cycle(); idle();

        // Jumps and invalid branch never train
        cycle(); fetch_pc = 32'hC0;
        res_valid = 1'b1; opcode = OP_JAL; res_pc = 32'hC0; zf = 1'b1;
        expect_v(K_SEL, 2, "jal_sel", 0); expect_v(K_MIS, 0, "jal_mis", 1);
        cycle(); opcode = OP_JALR;
        expect_v(K_SEL, 1, "jalr_sel", 0); expect_v(K_MIS, 0, "jalr_mis", 1);
        expect_v(K_PRED, 0, "jal_notrain", 0);
        cycle(); res_valid = 1'b0; opcode = OP_BRANCH; funct3 = 3'b000;
        expect_v(K_SEL, 0, "inval_sel", 0); expect_v(K_MIS, 0, "inval_mis", 1);
        expect_v(K_PRED, 0, "jalr_notrain", 0);
        cycle(); idle(); expect_v(K_PRED, 0, "inval_notrain", 0);

        // Collision (0x200 -> idx 0) and alias (0x000 / 0x100 -> idx 0)
        cycle(); fetch_pc = 32'h200; expect_v(K_PRED, 0, "coll_old", 0);
        br(3'b000, 4'b0100, 32'h200, 1'b0, 2'b10, 1'b1, 1'b1, "coll");
        cycle(); idle(); expect_v(K_PRED, 1, "coll_new", 0);
        cycle(); fetch_pc = 32'h100; expect_v(K_PRED, 1, "alias_p0", 0);
        br(3'b000, 4'b0000, 32'h000, 1'b1, 2'b00, 1'b1, 1'b1, "alias_dec");
        cycle(); idle(); expect_v(K_PRED, 0, "alias_p1", 0);
        cycle(); expect_v(K_PRED, 0, "alias_p2", 0);
        br(3'b001, 4'b0000, 32'h000, 1'b0, 2'b10, 1'b1, 1'b1, "alias_inc");
        cycle(); idle(); expect_v(K_PRED, 1, "alias_p3", 0);

        // Signed / unsigned compares and an unsupported funct3
        cycle(); br(3'b110, 4'b0000, 32'h4, 1'b1, 2'b10, 1'b0, 1'b1, "bltu_cf0");
        cycle(); br(3'b111, 4'b0000, 32'h4, 1'b0, 2'b00, 1'b0, 1'b1, "bgeu_cf0");
        cycle(); br(3'b100, 4'b0001, 32'h4, 1'b0, 2'b10, 1'b1, 1'b1, "blt_lt");
        cycle(); br(3'b101, 4'b0011, 32'h4, 1'b1, 2'b10, 1'b0, 1'b1, "bge_ge");
        cycle(); br(3'b101, 4'b0001, 32'h4, 1'b1, 2'b00, 1'b1, 1'b1, "bge_lt");
        cycle(); br(3'b110, 4'b1000, 32'h4, 1'b0, 2'b00, 1'b0, 1'b1, "bltu_cf1");
        cycle(); br(3'b111, 4'b1000, 32'h4, 1'b0, 2'b10, 1'b1, 1'b1, "bgeu_cf1");
        cycle(); br(3'b100, 4'b0011, 32'h4, 1'b0, 2'b00, 1'b0, 1'b1, "blt_ge");
        cycle(); br(3'b010, 4'b0100, 32'h8, 1'b1, 2'b00, 1'b0, 1'b0, "bad_f3");
        cycle(); idle();

`ifdef BPU_PERF_COUNTERS_EN
        expect_v(K_BR, exp_br, "br_count", 0);
        expect_v(K_MISS, exp_miss, "miss_count", 0);
`endif

        for (int n = 0; n < 10 && q.size() > 0; n++) cycle();
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
